sr_bank_writer: RTL and testbench

Write controller for a bank of N gated SR latches (active-high S/R inputs, level-sensitive gate). Accepts a word-write request, encodes it into per-bit set/reset commands, and sequences setup, gate pulse and hold so the latch bank is never driven with S=R=1 or with S/R changing while the gate is open. Then reads the latch outputs back and reports success or mismatch. It sits between the register-access logic and the latch bank, on the command side of the latch interface.

---
 rtl/sr_bank_writer.sv | 96 +++++++++
 tb/tb_sr_bank_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_writer.sv
// rtl/sr_bank_writer.sv - write sequencer for a gated SR latch bank
// Captures a set/clear mask at accept, drives setup/gate/hold/settle, then checks readback.
module sr_bank_writer #(
  parameter int N          = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [N-1:0] wr_data,
  output logic         wr_ack,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] s,
  output logic [N-1:0] r,
  output logic         le,
  input  logic [N-1:0] q_fb
);

  localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   data_q, set_q, clr_q;
  logic [CW-1:0]  cnt;
  logic           ack_q, err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      data_q <= '0;
      set_q  <= '0;
      clr_q  <= '0;
      cnt    <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      ack_q <= 1'b0;
      case (state)
        IDLE: if (wr_req) begin
          data_q <= wr_data;
          set_q  <= wr_data & ~q_fb;
          clr_q  <= ~wr_data & q_fb;
          err_q  <= 1'b0;
          ack_q  <= 1'b1;
        end
        SETUP:  cnt <= CW'(PULSE_CYC - 1);
        PULSE:  if (cnt != '0) cnt <= cnt - CW'(1);
        HOLD:   cnt <= CW'(SETTLE_CYC - 1);
        SETTLE: begin
          if (cnt == '0) err_q <= (q_fb != data_q);
          else           cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      // Equal data and readback means both change masks are empty: skip the latch.
      IDLE:    if (wr_req) state_nx = (wr_data == q_fb) ? DONE : SETUP;
      SETUP:   state_nx = PULSE;
      PULSE:   if (cnt == '0) state_nx = HOLD;
      HOLD:    state_nx = SETTLE;
      SETTLE:  if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // set_q and clr_q are disjoint by construction, so s & r is always zero.
  always_comb begin
    s      = '0;
    r      = '0;
    le     = (state == PULSE);
    busy   = (state != IDLE);
    done   = (state == DONE);
    wr_ack = ack_q;
    err    = err_q;
    case (state)
      SETUP, PULSE, HOLD: begin
        s = set_q;
        r = clr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// tb/tb_sr_bank_writer.sv - scoreboard bench for sr_bank_writer
// Driver pushes expected transactions; a negedge monitor checks every cycle against them.
module tb_sr_bank_writer;

  localparam int N   = 4;
  localparam int P   = 2;
  localparam int S   = 1;
  localparam int LAT = 3 + P + S;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_req = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         wr_ack, busy, done, err, le;
  logic [N-1:0] s, r, q_fb;

  sr_bank_writer #(.N(N), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .done(done), .err(err),
    .s(s), .r(r), .le(le), .q_fb(q_fb)
  );

  always #5 clk = ~clk;

  // Behavioural latch bank; stuck bits can never be set.
  logic         load_en = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] q_lat = '0;
  always @(negedge clk) begin
    if (load_en)  q_lat <= load_val;
    else if (le)  q_lat <= ((q_lat | s) & ~r) & ~stuck;
  end
  assign q_fb = q_lat;

  typedef struct packed {
    logic [N-1:0] d;
    logic [N-1:0] sm;
    logic [N-1:0] rm;
    logic         skip;
    logic         e;
  } txn_t;

  txn_t         exp_mem [0:255];
  logic [7:0]   wr_idx = '0;
  logic [7:0]   rd_idx = '0;
  logic [N-1:0] ref_fb = '0;

  int mon_checks = 0, mon_pass = 0, drv_checks = 0, drv_pass = 0;

  task automatic check_m(input string name, input int act, input int expv);
    mon_checks++;
    if (act == expv) mon_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic check_d(input string name, input int act, input int expv);
    drv_checks++;
    if (act == expv) drv_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference model: expected masks, path and error flag from the current readback.
  task automatic push_exp(input logic [N-1:0] d);
    txn_t t;
    t.d    = d;
    t.sm   = d & ~ref_fb;
    t.rm   = ~d & ref_fb;
    t.skip = (d == ref_fb);
    t.e    = ((d & ~stuck) != d);
    exp_mem[wr_idx] = t;
    wr_idx = wr_idx + 8'd1;
    ref_fb = d & ~stuck;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check_d("wait_idle", int'(busy), 0);
  endtask

  task automatic do_write(input logic [N-1:0] d);
    wait_idle();
    push_exp(d);
    wr_data = d;
    wr_req  = 1'b1;
    @(negedge clk); #1;
    wr_req  = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ack && n < 40);
  endtask

  // Monitor: expected {wr_ack,busy,done,le,err,s,r} for every cycle.
  logic rst_prev = 1'b0;
  always @(posedge clk) rst_prev <= rst;

  bit   active = 0;
  int   k = 0;
  txn_t cur;
  logic sticky = 1'b0;

  initial forever begin
    logic [12:0] act_v, exp_v;
    int lat;
    @(negedge clk);
    act_v = {wr_ack, busy, done, le, err, s, r};
    exp_v = '0;
    if (!rst_prev) begin
      active = 0;
      sticky = 1'b0;
      rd_idx = wr_idx;
    end else begin
      if (!active && wr_ack && rd_idx != wr_idx) begin
        cur    = exp_mem[rd_idx];
        active = 1;
        k      = 0;
      end
      if (active) begin
        k++;
        lat = cur.skip ? 1 : LAT;
        exp_v[12] = (k == 1);
        exp_v[11] = 1'b1;
        exp_v[10] = (k == lat);
        exp_v[9]  = !cur.skip && (k >= 2) && (k <= 1 + P);
        exp_v[8]  = (k == lat) ? cur.e : 1'b0;
        if (!cur.skip && k <= 2 + P) begin
          exp_v[7:4] = cur.sm;
          exp_v[3:0] = cur.rm;
        end
        if (k == lat) begin
          active = 0;
          sticky = cur.e;
          rd_idx = rd_idx + 8'd1;
        end
      end else begin
        exp_v[8] = sticky;
      end
    end
    check_m($sformatf("cycle k=%0d rst=%0d", k, rst_prev), int'(act_v), int'(exp_v));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [N-1:0] d;
    rst      = 1'b0;
    wr_req   = 1'b1;
    wr_data  = 4'b1010;
    load_en  = 1'b1;
    load_val = '0;
    repeat (3) @(negedge clk);
    #1;
    load_en = 1'b0;
    push_exp(4'b1010);
    rst = 1'b1;
    @(negedge clk); #1;
    wr_req = 1'b0;
    wait_idle();
    check_d("basic_readback", int'(q_fb), 10);

    do_write(4'b0110);
    do_write(4'b0110);

    stuck = 4'b0001;
    do_write(4'b0001);
    wait_idle();
    repeat (4) @(negedge clk);
    #1;
    stuck = 4'b0000;
    do_write(4'b0011);

    do_write(4'b0101);
    @(negedge clk); #1;
    wr_req  = 1'b1;
    wr_data = 4'b1111;
    @(negedge clk); #1;
    wr_req  = 1'b0;
    wait_idle();
    check_d("ignore_readback", int'(q_fb), 5);

    push_exp(4'b1010);
    wr_data = 4'b1010;
    wr_req  = 1'b1;
    wait_ack(n);
    for (int i = 0; i < 3; i++) begin
      #1;
      d = (i % 2 == 0) ? 4'b0101 : 4'b1010;
      wr_data = d;
      push_exp(d);
      wait_ack(n);
      check_d("accept_period", n, 4 + P + S);
    end
    #1;
    wr_req = 1'b0;

    do_write(4'b1111);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    rst      = 1'b1;
    load_en  = 1'b1;
    load_val = '0;
    @(negedge clk); #1;
    load_en = 1'b0;
    ref_fb  = '0;
    do_write(4'b0011);
    wait_idle();
    check_d("after_reset_readback", int'(q_fb), 3);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1;
      d = ($urandom_range(0, 3) == 0) ? ref_fb : 4'($urandom);
      do_write(d);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    #1;
    check_d("queue_drained", int'(rd_idx), int'(wr_idx));
    check_d("final_readback", int'(q_fb), int'(ref_fb));

    $display("%0d/%0d checks passed", mon_pass + drv_pass, mon_checks + drv_checks);
    $finish;
  end

endmodule
